// File: rtl/encap_mem_arb_pkg.sv
// encap_mem_arb_pkg: shared encodings and per-table defaults for encap memory arbitration
package encap_mem_arb_pkg;
  localparam int PIO_NBITS = 64;
  localparam int TUN_HASH_AW = 10;
  localparam int TUN_HASH_DW = 32;
  localparam int TUN_VAL_AW = 10;
  localparam int TUN_VAL_DW = 32;
  localparam int EKEY_HASH_AW = 10;
  localparam int EKEY_HASH_DW = 32;
  localparam int EKEY_VAL_AW = 10;
  localparam int EKEY_VAL_DW = 32;
  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_PEND = 2'd1,
    P_RD   = 2'd2,
    P_DONE = 2'd3
  } pio_state_e;
  localparam logic SRC_LU = 1'b0;
  localparam logic SRC_PIO = 1'b1;
endpackage

// File: rtl/encap_mem_rd_tag.sv
// encap_mem_rd_tag: RD_LAT-deep {valid, src} shift register; flush_pio kills in-flight PIO tags
module encap_mem_rd_tag #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_pio,
  input  logic in_vld,
  input  logic in_src,
  output logic out_vld,
  output logic out_src
);
  logic [RD_LAT-1:0] vld_q, src_q;
  logic [RD_LAT:0] vld_s, src_s;
  assign vld_s = {vld_q & ~(src_q & {RD_LAT{flush_pio}}), in_vld};
  assign src_s = {src_q, in_src};
  assign out_vld = vld_s[RD_LAT];
  assign out_src = src_s[RD_LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      src_q <= '0;
    end else begin
      vld_q <= vld_s[RD_LAT-1:0];
      src_q <= src_s[RD_LAT-1:0];
    end
  end
endmodule

// File: rtl/encap_mem_arb.sv
// encap_mem_arb: lookup/PIO arbiter for one single-port encap table memory.
// ENCAP_MEM_ARB_STATS_EN adds the saturating PIO stall counter.
module encap_mem_arb
  import encap_mem_arb_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int RD_LAT = 2,
  parameter int MAX_STARVE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lu_req,
  input  logic [AW-1:0]        lu_addr,
  output logic                 lu_gnt,
  output logic                 lu_rvalid,
  output logic [DW-1:0]        lu_rdata,
  input  logic                 reg_ms,
  input  logic                 reg_wr,
  input  logic                 reg_rd,
  input  logic [PIO_NBITS-1:0] reg_addr,
  input  logic [PIO_NBITS-1:0] reg_din,
  output logic                 mem_ack,
  output logic [PIO_NBITS-1:0] mem_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_q,
  input  logic                 stat_clr,
  output logic [15:0]          pio_stall_cnt
);
  localparam int SW = $clog2(MAX_STARVE + 1);
  pio_state_e state_q, state_d;
  logic op_we_q, op_we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [PIO_NBITS-1:0] rdata_q, rdata_d;
  logic [SW-1:0] starve_q, starve_d;
  logic lu_rvalid_q;
  logic [DW-1:0] lu_rdata_q;
  logic pio_pend, pio_win, abort, tag_vld, tag_src, pio_ret, lu_ret;
  assign pio_pend = state_q == P_PEND && reg_ms;
  assign pio_win = pio_pend && (!lu_req || starve_q == SW'(MAX_STARVE));
  assign lu_gnt = lu_req && !pio_win;
  assign mem_en = lu_gnt || pio_win;
  assign mem_we = pio_win && op_we_q;
  assign mem_addr = pio_win ? addr_q : lu_gnt ? lu_addr : '0;
  assign mem_wdata = mem_we ? din_q : '0;
  assign starve_d = pio_pend && !pio_win ? starve_q + 1'b1 : '0;
  assign abort = !reg_ms && (state_q == P_PEND || state_q == P_RD);
  assign pio_ret = tag_vld && tag_src == SRC_PIO;
  assign lu_ret = tag_vld && tag_src == SRC_LU;
  assign mem_ack = state_q == P_DONE;
  assign mem_rdata = rdata_q;
  assign lu_rvalid = lu_rvalid_q;
  assign lu_rdata = lu_rdata_q;
  encap_mem_rd_tag #(.RD_LAT(RD_LAT)) u_tag (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_pio(abort),
    .in_vld   (mem_en && !mem_we),
    .in_src   (pio_win),
    .out_vld  (tag_vld),
    .out_src  (tag_src)
  );
  always_comb begin
    state_d = state_q;
    op_we_d = op_we_q;
    addr_d = addr_q;
    din_d = din_q;
    rdata_d = rdata_q;
    case (state_q)
      P_IDLE: if (reg_ms && (reg_rd || reg_wr)) begin
        state_d = P_PEND;
        op_we_d = reg_wr;
        addr_d = reg_addr[AW-1:0];
        din_d = reg_din[DW-1:0];
      end
      P_PEND: state_d = !reg_ms ? P_IDLE : !pio_win ? P_PEND : op_we_q ? P_DONE : P_RD;
      P_RD: if (!reg_ms) state_d = P_IDLE;
        else if (pio_ret) begin
          state_d = P_DONE;
          rdata_d = PIO_NBITS'(mem_q);
        end
      P_DONE: if (!reg_ms) state_d = P_IDLE;
      default: state_d = P_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= P_IDLE;
      op_we_q <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
      rdata_q <= '0;
      starve_q <= '0;
      lu_rvalid_q <= 1'b0;
      lu_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_we_q <= op_we_d;
      addr_q <= addr_d;
      din_q <= din_d;
      rdata_q <= rdata_d;
      starve_q <= starve_d;
      lu_rvalid_q <= lu_ret;
      if (lu_ret) lu_rdata_q <= mem_q;
    end
  end
`ifdef ENCAP_MEM_ARB_STATS_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else if (stat_clr) stall_q <= '0;
    else if (pio_pend && !pio_win && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
  end
  assign pio_stall_cnt = stall_q;
  logic unused_bits;
  assign unused_bits = ^{reg_addr[PIO_NBITS-1:AW], reg_din[PIO_NBITS-1:DW]};
`else
  assign pio_stall_cnt = '0;
  logic unused_bits;
  assign unused_bits = ^{stat_clr, reg_addr[PIO_NBITS-1:AW], reg_din[PIO_NBITS-1:DW]};
`endif
endmodule

// File: tb/tb_encap_mem_arb.sv
// tb_encap_mem_arb: directed plus randomized checks of encap_mem_arb against a queue/array reference
module tb_encap_mem_arb;
  import encap_mem_arb_pkg::*;
  localparam int AW = 10, DW = 32, RD_LAT = 2, MAX_STARVE = 8;
  logic clk = 0, rst_n = 0;
  logic lu_req = 0, lu_gnt, lu_rvalid;
  logic [AW-1:0] lu_addr = '0;
  logic [DW-1:0] lu_rdata;
  logic reg_ms = 0, reg_wr = 0, reg_rd = 0;
  logic [PIO_NBITS-1:0] reg_addr = '0, reg_din = '0, mem_rdata;
  logic mem_ack, mem_en, mem_we, stat_clr = 0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_q;
  logic [15:0] pio_stall_cnt;
  int n_cmp = 0, n_bad = 0, cyc = 0, n_lu_ret = 0;
  always #5 clk = ~clk;
  encap_mem_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_STARVE(MAX_STARVE)) dut (
    .clk(clk), .rst_n(rst_n), .lu_req(lu_req), .lu_addr(lu_addr), .lu_gnt(lu_gnt),
    .lu_rvalid(lu_rvalid), .lu_rdata(lu_rdata), .reg_ms(reg_ms), .reg_wr(reg_wr),
    .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_din(reg_din), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_q(mem_q), .stat_clr(stat_clr), .pio_stall_cnt(pio_stall_cnt)
  );
  // memory environment: fixed-latency single-port RAM, garbage on idle cycles
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] ref_ram [2**AW];
  logic [DW-1:0] qp [RD_LAT];
  always @(posedge clk) begin
    cyc++;
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    qp[0] <= (mem_en && !mem_we) ? ram[mem_addr] : DW'($urandom);
    for (int i = 1; i < RD_LAT; i++) qp[i] <= qp[i-1];
  end
  assign mem_q = qp[RD_LAT-1];
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  typedef struct { logic [DW-1:0] d; int due; } exp_t;
  exp_t sb[$];
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else begin
      if (lu_rvalid) begin
        if (sb.size() == 0) check("lu_spurious", lu_rvalid, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("lu_rdata", lu_rdata, e.d);
          check("lu_latency", cyc, e.due);
          n_lu_ret++;
        end
      end
      if (lu_gnt) begin
        check("lu_mem_addr", mem_addr, lu_addr);
        sb.push_back('{ref_ram[lu_addr], cyc + RD_LAT + 1});
      end
    end
  end
  task automatic pio_acc(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, output int w);
    bit got;
    int lat;
    @(posedge clk); #1;
    reg_ms = 1; reg_wr = wr; reg_rd = !wr;
    reg_addr = {32'($urandom), 32'($urandom)};
    reg_addr[AW-1:0] = a;
    reg_din = {32'($urandom), d};
    @(posedge clk); #1;
    reg_wr = 0; reg_rd = 0;
    w = 0; got = 0;
    while (!got && w <= MAX_STARVE + 4) begin
      @(negedge clk);
      got = mem_en && !lu_gnt;
      if (!got) begin w++; @(posedge clk); end
    end
    check("pio_starve_bound", w <= MAX_STARVE, 1);
    if (got) begin
      check("pio_we", mem_we, wr);
      check("pio_addr", mem_addr, a);
      if (wr) check("pio_wdata", mem_wdata, d);
      lat = wr ? 1 : RD_LAT + 1;
      for (int i = 1; i <= lat; i++) begin @(negedge clk); check("pio_ack_time", mem_ack, i == lat); end
      if (!wr) check("pio_rdata", mem_rdata, {32'h0, ref_ram[a]});
      else ref_ram[a] = d;
      repeat (2) begin @(negedge clk); check("pio_ack_hold", mem_ack, 1); end
    end
    @(posedge clk); #1;
    reg_ms = 0;
    @(negedge clk); check("pio_ack_drop_cycle", mem_ack, got);
    @(negedge clk); check("pio_ack_clear", mem_ack, 0);
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_lu_rvalid"}, lu_rvalid, 0);
    check({tag, "_lu_rdata"}, lu_rdata, 0);
    check({tag, "_mem_ack"}, mem_ack, 0);
    check({tag, "_mem_rdata"}, mem_rdata, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_stall"}, pio_stall_cnt, 0);
  endtask
  initial begin
    int w, a;
    bit wr;
    for (int i = 0; i < 2**AW; i++) begin ram[i] = DW'($urandom); ref_ram[i] = ram[i]; end
    @(negedge clk);
    check_reset_vals("rst0");
    @(posedge clk); #1;
    rst_n = 1;
    pio_acc(1, 10'h05, 32'hA5A5_0001, w);
    check("wr_grant_wait", w, 0);
    pio_acc(0, 10'h05, '0, w);
    check("rd_grant_wait", w, 0);
    check("rd_rdata_zext", mem_rdata, 64'h0000_0000_A5A5_0001);
    n_lu_ret = 0;
    fork
      pio_acc(0, 10'h05, '0, w);
      begin
        a = 1;
        @(posedge clk); #1;
        for (int k = 1; k <= 20; k++) begin
          @(posedge clk); #1;
          lu_req = 1; lu_addr = AW'(a);
          @(negedge clk);
          check("starve_lu_gnt", lu_gnt, k != 9);
          if (lu_gnt) a++;
        end
        @(posedge clk); #1;
        lu_req = 0;
      end
    join
    check("starve_wait", w, MAX_STARVE);
    repeat (RD_LAT + 3) @(negedge clk);
    check("starve_lu_returns", n_lu_ret, 19);
`ifdef ENCAP_MEM_ARB_STATS_EN
    check("stall_cnt", pio_stall_cnt, 8);
    @(posedge clk); #1; stat_clr = 1;
    @(posedge clk); #1; stat_clr = 0;
    @(negedge clk); check("stall_clr", pio_stall_cnt, 0);
`else
    check("stall_cnt_off", pio_stall_cnt, 0);
`endif
    @(posedge clk); #1;
    reg_ms = 1; reg_rd = 1; reg_addr = 64'h7;
    @(posedge clk); #1;
    reg_rd = 0;
    @(negedge clk); check("abort_grant", mem_en && !mem_we, 1);
    @(posedge clk); #1;
    reg_ms = 0;
    repeat (6) begin @(negedge clk); check("abort_no_ack", mem_ack, 0); end
    pio_acc(0, 10'h09, '0, w);
    check("after_abort_wait", w, 0);
    fork
      begin
        bit hold;
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          hold = lu_req && !lu_gnt;
          @(posedge clk); #1;
          if (!hold) begin
            lu_req = $urandom_range(9) < 7;
            lu_addr = AW'($urandom_range(63));
          end
        end
        @(negedge clk);
        hold = lu_req && !lu_gnt;
        @(posedge clk); #1;
        lu_req = 0;
        if (hold) check("lu_drain_unheld", hold, 0);
      end
      begin
        for (int k = 0; k < 25; k++) begin
          wr = $urandom_range(1);
          a = wr ? 64 + int'($urandom_range(63)) : int'($urandom_range(127));
          pio_acc(wr, AW'(a), DW'($urandom), w);
          repeat ($urandom_range(3)) @(posedge clk);
        end
      end
    join
    repeat (RD_LAT + 4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    @(posedge clk); #1;
    lu_req = 1; lu_addr = 10'd1;
    @(posedge clk); #1;
    lu_addr = 10'd2;
    @(posedge clk); #1;
    lu_req = 0; rst_n = 0;
    @(negedge clk);
    check_reset_vals("rst_mid");
    @(posedge clk); #1;
    rst_n = 1;
    repeat (6) begin @(negedge clk); check("rst_no_rvalid", lu_rvalid, 0); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/encap_mem_arb.md
Name: encap_mem_arb

Overview:
- Arbiter/sequencer for one single-port encap table memory (tunnel hash, tunnel value, ekey hash or ekey value), one instance per memory.
- Shares the memory between the datapath lookup requester (high priority, pipelined) and the PIO path (one outstanding access from the encap PIO decoder).
- Produces the per-memory ack/rdata pair the PIO decoder consumes.
- Bounds PIO starvation under continuous lookup traffic.

Parameters:
- AW, 10, memory address width (depth 2^AW).
- DW, 32, memory data width; must be ≤ `PIO_NBITS.
- RD_LAT, 2, memory read latency in clocks from mem_en to mem_rdata valid (1..4).
- MAX_STARVE, 8, consecutive lookup wins after which a pending PIO access is forced through.

Ports:
- clk  in  1  core clock.
- `RESET_SIG  in  1  asynchronous, active-low reset.
- lu_req  in  1  lookup read request.
- lu_addr  in  AW  lookup address.
- lu_gnt  out  1  combinational; lookup accepted this cycle.
- lu_rvalid  out  1  lookup read data valid.
- lu_rdata  out  DW  lookup read data.
- reg_ms  in  1  memory select from the PIO decoder (level, held for the whole access).
- reg_wr  in  1  PIO write strobe.
- reg_rd  in  1  PIO read strobe.
- reg_addr  in  `PIO_NBITS  PIO address; low AW bits used.
- reg_din  in  `PIO_NBITS  PIO write data; low DW bits used.
- mem_ack  out  1  PIO access complete; held until reg_ms falls.
- mem_rdata  out  `PIO_NBITS  PIO read data, zero-extended; held with mem_ack.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_q  in  DW  memory read data.
- stat_clr  in  1  clears the statistics counter.
- pio_stall_cnt  out  16  statistics; see Optional Feature.

Behaviour:
- Reset values: lu_rvalid=0, lu_rdata=0, mem_ack=0, mem_rdata=0, starve_cnt=0, tag pipe=0, PIO FSM=P_IDLE, pio_stall_cnt=0.
- mem_en/we/addr/wdata are combinational from the grant and are 0 when nothing is granted.
- PIO FSM states: P_IDLE, P_PEND, P_RD, P_DONE.
  - P_IDLE -> P_PEND on reg_ms&(reg_rd|reg_wr). Latch op, addr[AW-1:0] and din[DW-1:0].
  - P_PEND -> P_DONE on grant of a write; the memory write occurs in the grant cycle.
  - P_PEND -> P_RD on grant of a read.
  - P_RD -> P_DONE when the tagged PIO read data returns, RD_LAT cycles after the grant. mem_rdata is captured in that cycle.
  - P_DONE drives mem_ack=1 and -> P_IDLE when reg_ms=0; mem_ack clears in the same cycle.
  - Strobes arriving outside P_IDLE are ignored (one outstanding access only).
- Arbitration, at most one mem_en per cycle:
  - Lookup only: lookup is granted.
  - PIO pending only: PIO is granted.
  - Both: lookup wins unless starve_cnt==MAX_STARVE, in which case PIO wins.
  - starve_cnt increments on each PIO-pending cycle lost to lookup and clears on PIO grant or when no PIO is pending.
- lu_gnt = lu_req & ~pio_win. A lookup that is not granted must be held by the requester.
- Read return: a RD_LAT-deep tag shift register records {valid, src} per grant.
  - Lookup tag: lu_rvalid=1 and lu_rdata=mem_q, registered, so rvalid appears RD_LAT+1 cycles after lu_gnt.
  - PIO tag: capture into mem_rdata.
  - lu_rdata holds its last value when lu_rvalid=0.
- Boundaries:
  - Back-to-back lookups at full rate are sustained; the PIO gets the slot every MAX_STARVE+1 cycles.
  - reg_ms dropping during P_PEND or P_RD aborts the access: return to P_IDLE and drop any returning PIO data. A write already granted stays committed.
  - Reset mid-operation clears the tag pipe, so in-flight read data is discarded.

Optional Feature:
- Macro ENCAP_MEM_ARB_STATS_EN.
- Defined: pio_stall_cnt counts cycles with a PIO access pending and not granted. It saturates at 16'hFFFF and clears on stat_clr; stat_clr wins over a same-cycle increment.
- Undefined: pio_stall_cnt is tied to 0, stat_clr is ignored, and no counter logic is instantiated.

Decomposition:
- Shared encap package/defines hold:
  - PIO FSM state encodings (P_IDLE=2'd0, P_PEND=2'd1, P_RD=2'd2, P_DONE=2'd3).
  - Tag source encodings (SRC_LU=0, SRC_PIO=1).
  - Default AW/DW per encap table.
- One natural sub-module: encap_mem_rd_tag, the parameterised RD_LAT-deep valid/src shift register with a flush input.

Test Plan:
- PIO write addr 0x05 data 0xA5A5_0001, no lookups -> mem_en=mem_we=1 with addr 0x05 in the cycle after the strobe; mem_ack=1 the next cycle and held until reg_ms falls.
- PIO read addr 0x05 after the write -> mem_ack with mem_rdata=0x0000_0000_A5A5_0001 (zero-extended) RD_LAT+1 cycles after the grant.
- lu_req held high for 20 cycles while a PIO read is pending, MAX_STARVE=8 -> PIO granted in the 9th contention cycle; lu_gnt=0 only in that cycle; all 19 lookups return lu_rvalid in order.
- PIO read launched with reg_ms deasserted one cycle after the grant -> returning data dropped, mem_ack never asserts, FSM returns to P_IDLE, and the next PIO access completes normally.
- `RESET_SIG asserted with 2 lookup reads in flight -> no lu_rvalid after reset release; all outputs at their reset values.
- With ENCAP_MEM_ARB_STATS_EN, 8 lost contention cycles -> pio_stall_cnt=8; stat_clr -> 0.
